mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-003 SHALL have port in_valid, input, 1, meaning in_params holds a valid EX/MEM entry.
REQ-004 SHALL have port in_params, input, mem_params_t, carrying rd_addr, rd_data (ALU result or address), mem_op and mem_data.
REQ-005 SHALL have port in_ready, output, 1, meaning the entry is accepted this cycle; low stalls upstream.
REQ-006 SHALL have port bus_req, output, 1, the data-bus request.
REQ-007 SHALL have port bus_addr, output, u32_t, the word address.
REQ-008 SHALL have port bus_we, output, 1, meaning write when high.
REQ-009 SHALL have port bus_wrstb, output, wrstb_t, the byte write strobes.
REQ-010 SHALL have port bus_wdata, output, u32_t, the store data.
REQ-011 SHALL have port bus_ack, input, 1, meaning the request completes this cycle.
REQ-012 SHALL have port bus_rdata, input, u32_t, the load data, valid with bus_ack.
REQ-013 SHALL have port out_valid, output, 1, meaning out_params is valid for MEM/WB this cycle.
REQ-014 SHALL have port out_params, output, wb_params_t, carrying rd_addr and rd_data to writeback.

Function
REQ-015 SHALL implement FSM states IDLE and BUS; in_ready = (state == IDLE).
REQ-016 IDLE, in_valid, mem_op NONE or 2'b11: next cycle out_valid=1, out_params={rd_addr, rd_data}; stay IDLE (1-cycle latency, back-to-back every cycle).
REQ-017 IDLE, in_valid, mem_op LOAD/STORE: capture entry; next cycle state=BUS, bus_req=1, bus_addr={rd_data[31:2],2'b00}, bus_we=(STORE), bus_wrstb=STORE?4'hF:4'h0, bus_wdata=mem_data.
REQ-018 IDLE, in_valid low: out_valid=0 next cycle; out_params holds last value.
REQ-019 BUS: bus_req and all bus_* outputs SHALL stay stable until the cycle bus_ack=1, including the first BUS cycle (zero-wait ack).
REQ-020 BUS with bus_ack, LOAD: next cycle out_valid=1, out_params={captured rd_addr, bus_rdata}, bus_req=0, state=IDLE.
REQ-021 BUS with bus_ack, STORE: next cycle out_valid=1, out_params={5'd0, 32'd0} (no register write), bus_req=0, state=IDLE.
REQ-022 BUS without bus_ack: out_valid=0; wait indefinitely; no timeout.
REQ-023 Load/store latency: accept cycle + N wait cycles + 1, i.e. out_valid 2+N cycles after acceptance.
REQ-024 bus_ack while state=IDLE SHALL be ignored; bus_rdata is sampled only on ack in BUS.
REQ-025 rd_data[1:0] != 0 SHALL be silently truncated (word access only); no exception.
REQ-026 No new entry is accepted in the cycle BUS completes; next acceptance occurs earliest the following (IDLE) cycle.

Reset
REQ-027 rst_n low SHALL immediately force state=IDLE, in_ready=1, bus_req=0, bus_we=0, bus_wrstb=0, bus_addr=0, bus_wdata=0, out_valid=0, out_params=0.
REQ-028 Reset mid-BUS SHALL abandon the transaction; a late bus_ack after reset is ignored per REQ-024.

Structure
REQ-029 Package types SHALL gain mem_state_e (IDLE, BUS) and constant WRSTB_WORD=4'hF; mem_params_t/wb_params_t are reused unchanged.
REQ-030 SHALL be a single module; no sub-module is required.

Verification
REQ-031 NONE op: rd_addr=5, rd_data=0x1234 -> next cycle out_valid=1, out_params={5,0x1234}; in_ready stays 1.
REQ-032 LOAD addr 0x100, ack after 3 waits, rdata 0xDEADBEEF -> bus_req 4 cycles at 0x100, in_ready low, then out={rd_addr,0xDEADBEEF}.
REQ-033 STORE addr 0x203, data 0xCAFEF00D, zero-wait ack -> bus_addr 0x200, we=1, wrstb=0xF, then out={0,0}, out_valid=1.
REQ-034 Back-to-back NONE, LOAD, NONE with in_valid held high -> second NONE accepted only after LOAD completes; outputs in order.
REQ-035 rst_n asserted during BUS wait, then ack -> bus_req drops asynchronously, no out_valid, late ack ignored.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM pipeline stage: EX/MEM entry, writeback entry,
// memory op encoding and the stage FSM states.
package mem_stage_pkg;

    typedef logic [31:0] u32_t;
    typedef logic [3:0]  wrstb_t;
    typedef logic [4:0]  reg_addr_t;

    // 2'b11 is reserved and passes straight through like NONE
    typedef enum logic [1:0] {
        MEM_NONE  = 2'b00,
        MEM_LOAD  = 2'b01,
        MEM_STORE = 2'b10,
        MEM_RSVD  = 2'b11
    } mem_op_e;

    typedef struct packed {
        reg_addr_t rd_addr;
        u32_t      rd_data;
        mem_op_e   mem_op;
        u32_t      mem_data;
    } mem_params_t;

    typedef struct packed {
        reg_addr_t rd_addr;
        u32_t      rd_data;
    } wb_params_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } mem_state_e;

    localparam wrstb_t WRSTB_WORD = 4'hF;

    // Word-only bus: low address bits are dropped without complaint
    function automatic u32_t word_addr(input u32_t a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_stage.sv
// MEM stage: pass-through ops in 1 cycle, load/store in 2+N cycles (N bus waits).
// Backpressure: in_ready low for the whole bus access; bus_* held until bus_ack.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  mem_params_t in_params,
    output logic        in_ready,
    output logic        bus_req,
    output u32_t        bus_addr,
    output logic        bus_we,
    output wrstb_t      bus_wrstb,
    output u32_t        bus_wdata,
    input  logic        bus_ack,
    input  u32_t        bus_rdata,
    output logic        out_valid,
    output wb_params_t  out_params
);

    mem_state_e state;
    mem_state_e state_nxt;
    reg_addr_t  cap_rd_addr;
    logic       is_mem;

    assign is_mem   = (in_params.mem_op == MEM_LOAD) || (in_params.mem_op == MEM_STORE);
    assign in_ready = (state == IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid && is_mem) state_nxt = BUS;
            BUS:     if (bus_ack)            state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_req     <= 1'b0;
            bus_addr    <= '0;
            bus_we      <= 1'b0;
            bus_wrstb   <= '0;
            bus_wdata   <= '0;
            cap_rd_addr <= '0;
            out_valid   <= 1'b0;
            out_params  <= '0;
        end else begin
            out_valid <= 1'b0;
            if (state == IDLE && in_valid) begin
                if (is_mem) begin
                    bus_req     <= 1'b1;
                    bus_addr    <= word_addr(in_params.rd_data);
                    bus_we      <= (in_params.mem_op == MEM_STORE);
                    bus_wrstb   <= (in_params.mem_op == MEM_STORE) ? WRSTB_WORD : '0;
                    bus_wdata   <= in_params.mem_data;
                    cap_rd_addr <= in_params.rd_addr;
                end else begin
                    out_valid          <= 1'b1;
                    out_params.rd_addr <= in_params.rd_addr;
                    out_params.rd_data <= in_params.rd_data;
                end
            end else if (state == BUS && bus_ack) begin
                bus_req   <= 1'b0;
                bus_we    <= 1'b0;
                bus_wrstb <= '0;
                out_valid <= 1'b1;
                // Stores retire with a null writeback so WB never touches the regfile
                if (bus_we) begin
                    out_params <= '0;
                end else begin
                    out_params.rd_addr <= cap_rd_addr;
                    out_params.rd_data <= bus_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    mem_params_t in_params;
    logic        in_ready;
    logic        bus_req;
    u32_t        bus_addr;
    logic        bus_we;
    wrstb_t      bus_wrstb;
    u32_t        bus_wdata;
    logic        bus_ack;
    u32_t        bus_rdata;
    logic        out_valid;
    wb_params_t  out_params;

    int errors = 0;
    int checks = 0;
    int n_out  = 0;

    mem_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_params  (in_params),
        .in_ready   (in_ready),
        .bus_req    (bus_req),
        .bus_addr   (bus_addr),
        .bus_we     (bus_we),
        .bus_wrstb  (bus_wrstb),
        .bus_wdata  (bus_wdata),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata),
        .out_valid  (out_valid),
        .out_params (out_params)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: at most one outstanding memory access; results retire in issue order.
    logic       m_busy;
    logic       m_store;
    u32_t       m_addr;
    u32_t       m_wdata;
    logic [4:0] m_rd;
    logic       e_valid;
    wb_params_t e_out;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_busy  = 1'b0;
            e_valid = 1'b0;
            e_out   = '0;
        end
        chk("m_in_ready",  {63'd0, in_ready},  {63'd0, !m_busy});
        chk("m_out_valid", {63'd0, out_valid}, {63'd0, e_valid});
        chk("m_out_params", {27'd0, out_params}, {27'd0, e_out});
        chk("m_bus_req",   {63'd0, bus_req},   {63'd0, m_busy});
        if (m_busy) begin
            chk("m_bus_addr",  {32'd0, bus_addr},  {32'd0, m_addr});
            chk("m_bus_we",    {63'd0, bus_we},    {63'd0, m_store});
            chk("m_bus_wrstb", {60'd0, bus_wrstb}, {60'd0, (m_store ? 4'hF : 4'h0)});
            chk("m_bus_wdata", {32'd0, bus_wdata}, {32'd0, m_wdata});
        end
        if (out_valid) n_out++;
        if (rst_n) begin
            e_valid = 1'b0;
            if (!m_busy) begin
                if (in_valid) begin
                    if (in_params.mem_op == MEM_LOAD || in_params.mem_op == MEM_STORE) begin
                        m_busy  = 1'b1;
                        m_store = (in_params.mem_op == MEM_STORE);
                        m_addr  = in_params.rd_data & 32'hFFFF_FFFC;
                        m_wdata = in_params.mem_data;
                        m_rd    = in_params.rd_addr;
                    end else begin
                        e_valid = 1'b1;
                        e_out   = '{rd_addr: in_params.rd_addr, rd_data: in_params.rd_data};
                    end
                end
            end else if (bus_ack) begin
                m_busy  = 1'b0;
                e_valid = 1'b1;
                e_out   = m_store ? '0 : '{rd_addr: m_rd, rd_data: bus_rdata};
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [4:0] a, input u32_t d, input mem_op_e op, input u32_t md);
        in_valid  = 1'b1;
        in_params = '{rd_addr: a, rd_data: d, mem_op: op, mem_data: md};
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_params = '0;
        bus_ack   = 1'b0;
        bus_rdata = '0;
        #1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_bus_req",  {63'd0, bus_req},  64'd0);
        chk("rst_bus_addr", {32'd0, bus_addr}, 64'd0);
        chk("rst_bus_we",   {63'd0, bus_we},   64'd0);
        chk("rst_wrstb",    {60'd0, bus_wrstb}, 64'd0);
        chk("rst_wdata",    {32'd0, bus_wdata}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_params", {27'd0, out_params}, 64'd0);
        step(); step();
        @(negedge clk); #1 rst_n = 1'b1;
        step();

        // NONE pass-through
        set_in(5'd5, 32'h1234, MEM_NONE, 32'h0);
        step();
        in_valid = 1'b0;
        chk("none_valid",  {63'd0, out_valid}, 64'd1);
        chk("none_params", {27'd0, out_params}, {27'd0, 5'd5, 32'h1234});
        chk("none_ready",  {63'd0, in_ready}, 64'd1);
        step();

        // LOAD with three wait states
        set_in(5'd7, 32'h100, MEM_LOAD, 32'h0);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("load_req",   {63'd0, bus_req},  64'd1);
            chk("load_addr",  {32'd0, bus_addr}, 64'h100);
            chk("load_ready", {63'd0, in_ready}, 64'd0);
            chk("load_wait_valid", {63'd0, out_valid}, 64'd0);
            bus_ack   = (i == 3);
            bus_rdata = (i == 3) ? 32'hDEADBEEF : 32'h0;
            step();
        end
        bus_ack = 1'b0;
        chk("load_valid",  {63'd0, out_valid}, 64'd1);
        chk("load_params", {27'd0, out_params}, {27'd0, 5'd7, 32'hDEADBEEF});
        chk("load_req_off", {63'd0, bus_req}, 64'd0);
        step();

        // STORE, misaligned address, zero-wait ack
        set_in(5'd9, 32'h203, MEM_STORE, 32'hCAFEF00D);
        step();
        in_valid = 1'b0;
        chk("st_req",   {63'd0, bus_req},   64'd1);
        chk("st_addr",  {32'd0, bus_addr},  64'h200);
        chk("st_we",    {63'd0, bus_we},    64'd1);
        chk("st_wrstb", {60'd0, bus_wrstb}, 64'hF);
        chk("st_wdata", {32'd0, bus_wdata}, 64'hCAFEF00D);
        bus_ack = 1'b1;
        step();
        bus_ack = 1'b0;
        chk("st_valid",  {63'd0, out_valid}, 64'd1);
        chk("st_params", {27'd0, out_params}, 64'd0);
        step();

        // NONE, LOAD, NONE back to back with in_valid held
        set_in(5'd1, 32'd11, MEM_NONE, 32'h0);
        step();
        chk("b2b_o1", {27'd0, out_params}, {27'd0, 5'd1, 32'd11});
        set_in(5'd2, 32'h40, MEM_LOAD, 32'h0);
        step();
        set_in(5'd3, 32'd33, MEM_RSVD, 32'h0);
        chk("b2b_ready_bus", {63'd0, in_ready}, 64'd0);
        step();
        chk("b2b_wait_valid", {63'd0, out_valid}, 64'd0);
        bus_ack   = 1'b1;
        bus_rdata = 32'h55;
        step();
        bus_ack = 1'b0;
        chk("b2b_o2", {27'd0, out_params}, {27'd0, 5'd2, 32'h55});
        chk("b2b_ready_back", {63'd0, in_ready}, 64'd1);
        step();
        in_valid = 1'b0;
        chk("b2b_o3_valid", {63'd0, out_valid}, 64'd1);
        chk("b2b_o3", {27'd0, out_params}, {27'd0, 5'd3, 32'd33});
        step();

        // Reset during a bus wait, then a late ack
        set_in(5'd4, 32'h80, MEM_LOAD, 32'h0);
        step();
        in_valid = 1'b0;
        step();
        chk("rb_req_before", {63'd0, bus_req}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rb_req_async",  {63'd0, bus_req},  64'd0);
        chk("rb_ready",      {63'd0, in_ready}, 64'd1);
        chk("rb_out_valid",  {63'd0, out_valid}, 64'd0);
        step();
        bus_ack   = 1'b1;
        bus_rdata = 32'h77;
        @(negedge clk); #1 rst_n = 1'b1;
        step();
        chk("rb_late_ack_valid", {63'd0, out_valid}, 64'd0);
        chk("rb_late_ack_req",   {63'd0, bus_req},   64'd0);
        bus_ack = 1'b0;
        step();

        // Randomized traffic with a random-latency responder and stray acks
        n_out = 0;
        fork
            begin
                logic acc;
                for (int c = 0; c < 3000; c++) begin
                    @(negedge clk);
                    acc = in_valid && in_ready;
                    @(posedge clk);
                    #1;
                    if (acc || !in_valid) begin
                        if ($urandom_range(3) == 0) begin
                            in_valid = 1'b0;
                        end else begin
                            in_valid  = 1'b1;
                            in_params = '{rd_addr: 5'($urandom), rd_data: $urandom,
                                          mem_op: mem_op_e'($urandom_range(3)), mem_data: $urandom};
                        end
                    end
                end
                in_valid = 1'b0;
            end
            begin
                logic in_txn;
                int   cnt;
                int   n;
                in_txn = 1'b0;
                cnt    = 0;
                n      = 0;
                for (int c = 0; c < 3000; c++) begin
                    @(posedge clk);
                    #1;
                    bus_rdata = $urandom;
                    if (!bus_req) begin
                        in_txn  = 1'b0;
                        bus_ack = ($urandom_range(3) == 0);
                    end else begin
                        if (!in_txn) begin
                            in_txn = 1'b1;
                            cnt    = 0;
                            n      = $urandom_range(3);
                        end
                        bus_ack = (cnt == n);
                        cnt++;
                    end
                end
            end
        join
        // Drain any outstanding access with a prompt ack
        for (int c = 0; c < 8; c++) begin
            bus_ack = bus_req;
            step();
        end
        bus_ack = 1'b0;
        step(); step();
        checks++;
        if (n_out < 100) begin
            errors++;
            $display("FAIL rnd_throughput: got %0d outputs expected at least 100", n_out);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
